// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - two-port (fetch/vector) to one memory bus arbiter; optional stats via CORE_MEM_ARB_STATS_EN
module core_mem_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int DATA_W     = 64,
    parameter int V_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic              f_req_write,
    input  logic [ADDR_W-1:0] f_req_addr,
    input  logic [DATA_W-1:0] f_req_wdata,
    output logic              f_resp_valid,
    output logic [DATA_W-1:0] f_resp_rdata,
    input  logic              v_req_valid,
    output logic              v_req_ready,
    input  logic              v_req_write,
    input  logic [ADDR_W-1:0] v_req_addr,
    input  logic [DATA_W-1:0] v_req_wdata,
    output logic              v_resp_valid,
    output logic [DATA_W-1:0] v_resp_rdata,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_req_write,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_rdata
`ifdef CORE_MEM_ARB_STATS_EN
    ,
    output logic [31:0]       f_grant_cnt,
    output logic [31:0]       v_grant_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state, state_nxt;
    logic                grant_f, grant_v;
    logic                prio_v;     // 1: V wins the next conflict
    logic                owner_v;    // 1: transaction in flight belongs to V
    logic                lat_write;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    // Next-state and grant decision; grants only exist in IDLE
    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_v   = 1'b0;
        case (state)
            S_IDLE: begin
                if (f_req_valid && v_req_valid) begin
                    grant_v = prio_v;
                    grant_f = !prio_v;
                end else begin
                    grant_f = f_req_valid;
                    grant_v = v_req_valid;
                end
                if (grant_f || grant_v) state_nxt = S_ISSUE;
            end
            S_ISSUE: if (m_req_ready)  state_nxt = S_WAIT;
            S_WAIT:  if (m_resp_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Ready is gated by reset so nothing is acknowledged while held in reset
    assign f_req_ready = grant_f && rst_n;
    assign v_req_ready = grant_v && rst_n;
    assign m_req_valid = (state == S_ISSUE);
    assign m_req_write = lat_write;
    assign m_req_addr  = lat_addr;
    assign m_req_wdata = lat_wdata;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Latch the winning request, its owner and the round-robin pointer on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_v    <= (V_PRIORITY != 0);
            owner_v   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_f) begin
            prio_v    <= 1'b1;
            owner_v   <= 1'b0;
            lat_write <= f_req_write;
            lat_addr  <= f_req_addr;
            lat_wdata <= f_req_wdata;
        end else if (grant_v) begin
            prio_v    <= 1'b0;
            owner_v   <= 1'b1;
            lat_write <= v_req_write;
            lat_addr  <= v_req_addr;
            lat_wdata <= v_req_wdata;
        end
    end

    // Route the downstream response to the owner as a registered one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_resp_valid <= 1'b0;
            v_resp_valid <= 1'b0;
            f_resp_rdata <= '0;
            v_resp_rdata <= '0;
        end else begin
            f_resp_valid <= 1'b0;
            v_resp_valid <= 1'b0;
            if (state == S_WAIT && m_resp_valid) begin
                if (owner_v) begin
                    v_resp_valid <= 1'b1;
                    v_resp_rdata <= m_resp_rdata;
                end else begin
                    f_resp_valid <= 1'b1;
                    f_resp_rdata <= m_resp_rdata;
                end
            end
        end
    end

`ifdef CORE_MEM_ARB_STATS_EN
    // Free-running grant and conflict counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_grant_cnt  <= '0;
            v_grant_cnt  <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant_f) f_grant_cnt <= f_grant_cnt + 32'd1;
            if (grant_v) v_grant_cnt <= v_grant_cnt + 32'd1;
            if (state == S_IDLE && f_req_valid && v_req_valid)
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - randomized self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;
    localparam int AW = 21;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req_valid, f_req_ready, f_req_write, f_resp_valid;
    logic [AW-1:0] f_req_addr;
    logic [DW-1:0] f_req_wdata, f_resp_rdata;
    logic          v_req_valid, v_req_ready, v_req_write, v_resp_valid;
    logic [AW-1:0] v_req_addr;
    logic [DW-1:0] v_req_wdata, v_resp_rdata;
    logic          m_req_valid, m_req_ready, m_req_write, m_resp_valid;
    logic [AW-1:0] m_req_addr;
    logic [DW-1:0] m_req_wdata, m_resp_rdata;
`ifdef CORE_MEM_ARB_STATS_EN
    logic [31:0]   f_grant_cnt, v_grant_cnt, conflict_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit last_v;                       // port granted most recently (0 = F)
    logic [DW-1:0] exp_rd_f, exp_rd_v;  // last response data each port should show

    always #5 clk = ~clk;

    core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .V_PRIORITY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_write(f_req_write),
        .f_req_addr(f_req_addr), .f_req_wdata(f_req_wdata),
        .f_resp_valid(f_resp_valid), .f_resp_rdata(f_resp_rdata),
        .v_req_valid(v_req_valid), .v_req_ready(v_req_ready), .v_req_write(v_req_write),
        .v_req_addr(v_req_addr), .v_req_wdata(v_req_wdata),
        .v_resp_valid(v_resp_valid), .v_resp_rdata(v_resp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata)
`ifdef CORE_MEM_ARB_STATS_EN
        , .f_grant_cnt(f_grant_cnt), .v_grant_cnt(v_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    task automatic do_reset();
        f_req_valid = 0; v_req_valid = 0; m_req_ready = 0; m_resp_valid = 0;
        f_req_write = 0; v_req_write = 0; f_req_addr = '0; v_req_addr = '0;
        f_req_wdata = '0; v_req_wdata = '0; m_resp_rdata = '0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        last_v = 0;
        exp_rd_f = '0;
        exp_rd_v = '0;
    endtask

    // Drive one granted transaction through the downstream bus and check the routed response
    task automatic serve(input bit pv, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int rdy_wait, input int resp_wait);
        logic [DW-1:0] rd;
        rd = {$urandom, $urandom};
        for (int i = 0; i <= rdy_wait; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (pv) v_req_valid = 0; else f_req_valid = 0;
            end
            m_req_ready  = (i == rdy_wait);
            m_resp_valid = 1'($urandom_range(0, 1));
            #1;
            n_vec++;
            if ({m_req_valid, m_req_write, m_req_addr, m_req_wdata} !== {1'b1, w, a, d}) begin
                n_err++;
                $display("FAIL issue_fields got %h exp %h", {m_req_valid, m_req_write, m_req_addr, m_req_wdata}, {1'b1, w, a, d});
            end
            n_vec++;
            if ({f_req_ready, v_req_ready, f_resp_valid, v_resp_valid} !== 4'b0) begin
                n_err++;
                $display("FAIL issue_quiet got %b exp 0000", {f_req_ready, v_req_ready, f_resp_valid, v_resp_valid});
            end
        end
        @(negedge clk);
        m_req_ready  = 0;
        m_resp_valid = 0;
        for (int j = 0; j <= resp_wait; j++) begin
            if (j != 0) @(negedge clk);
            #1;
            n_vec++;
            if ({m_req_valid, f_req_ready, v_req_ready, f_resp_valid, v_resp_valid} !== 5'b0) begin
                n_err++;
                $display("FAIL wait_quiet got %b exp 00000", {m_req_valid, f_req_ready, v_req_ready, f_resp_valid, v_resp_valid});
            end
        end
        m_resp_valid = 1;
        m_resp_rdata = rd;
        @(negedge clk);
        m_resp_valid = 0;
        m_resp_rdata = {$urandom, $urandom};
        if (pv) exp_rd_v = rd; else exp_rd_f = rd;
        #1;
        n_vec++;
        if ({f_resp_valid, v_resp_valid, m_req_valid} !== {!pv, pv, 1'b0}) begin
            n_err++;
            $display("FAIL resp_pulse got %b exp %b", {f_resp_valid, v_resp_valid, m_req_valid}, {!pv, pv, 1'b0});
        end
        n_vec++;
        if ({f_resp_rdata, v_resp_rdata} !== {exp_rd_f, exp_rd_v}) begin
            n_err++;
            $display("FAIL resp_data got %h exp %h", {f_resp_rdata, v_resp_rdata}, {exp_rd_f, exp_rd_v});
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        f_req_valid = 1; v_req_valid = 1; m_req_ready = 1; m_resp_valid = 1;
        f_req_addr = 21'h1234; v_req_addr = 21'h4321; m_resp_rdata = {$urandom, $urandom};
        @(negedge clk);
        #1;
        n_vec++;
        if ({f_req_ready, f_resp_valid, f_resp_rdata, v_req_ready, v_resp_valid, v_resp_rdata,
             m_req_valid, m_req_write, m_req_addr, m_req_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b%b%b%b%b%b exp 0", f_req_ready, v_req_ready, f_resp_valid, v_resp_valid, m_req_valid, m_req_write);
        end
        do_reset();
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready, m_req_valid, f_resp_valid, v_resp_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_idle got %b exp 00000", {f_req_ready, v_req_ready, m_req_valid, f_resp_valid, v_resp_valid});
        end
    endtask

    task automatic test_single_f_read();
        logic [DW-1:0] wd;
        do_reset();
        wd = {$urandom, $urandom};
        f_req_valid = 1; f_req_write = 0; f_req_addr = 21'h00100; f_req_wdata = wd;
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL single_grant got %b exp 10", {f_req_ready, v_req_ready});
        end
        serve(0, 0, 21'h00100, wd, 0, 1);
    endtask

    task automatic test_conflict();
        do_reset();
        f_req_valid = 1; f_req_write = 0; f_req_addr = 21'h10; f_req_wdata = 64'h1;
        v_req_valid = 1; v_req_write = 0; v_req_addr = 21'h20; v_req_wdata = 64'h2;
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL conflict_first got %b exp 01", {f_req_ready, v_req_ready});
        end
        serve(1, 0, 21'h20, 64'h2, 0, 0);
        v_req_valid = 1; v_req_addr = 21'h30; v_req_wdata = 64'h3;
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL conflict_second got %b exp 10", {f_req_ready, v_req_ready});
        end
        serve(0, 0, 21'h10, 64'h1, 0, 0);
`ifdef CORE_MEM_ARB_STATS_EN
        n_vec++;
        if (!(v_grant_cnt == 32'd1 && f_grant_cnt == 32'd1 && conflict_cnt >= 32'd1)) begin
            n_err++;
            $display("FAIL stats got v=%0d f=%0d c=%0d exp v=1 f=1 c>=1", v_grant_cnt, f_grant_cnt, conflict_cnt);
        end
`endif
        f_req_valid = 1; f_req_addr = 21'h40; f_req_wdata = 64'h4;
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL conflict_third got %b exp 01", {f_req_ready, v_req_ready});
        end
        serve(1, 0, 21'h30, 64'h3, 1, 0);
        f_req_valid = 0;
    endtask

    task automatic test_v_write();
        do_reset();
        v_req_valid = 1; v_req_write = 1; v_req_addr = 21'h1FFFF0; v_req_wdata = 64'hDEADBEEF;
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL write_grant got %b exp 01", {f_req_ready, v_req_ready});
        end
        serve(1, 1, 21'h1FFFF0, 64'hDEADBEEF, 3, 0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        v_req_valid = 1; v_req_write = 0; v_req_addr = 21'h55; v_req_wdata = 64'h5;
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_first got %b exp 01", {f_req_ready, v_req_ready});
        end
        f_req_valid = 1; f_req_write = 1; f_req_addr = 21'h77; f_req_wdata = 64'hCAFE_F00D_0123_4567;
        serve(1, 0, 21'h55, 64'h5, 2, 2);
        #1;
        n_vec++;
        if ({f_req_ready, v_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL bp_second got %b exp 10", {f_req_ready, v_req_ready});
        end
        serve(0, 1, 21'h77, 64'hCAFE_F00D_0123_4567, 1, 2);
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        f_req_valid = 1; f_req_write = 0; f_req_addr = 21'h123; f_req_wdata = 64'h9;
        @(negedge clk);
        f_req_valid = 0; m_req_ready = 1;
        @(negedge clk);
        m_req_ready = 0;
        f_req_valid = 1; v_req_valid = 1;
        #2 rst_n = 0;
        #1;
        n_vec++;
        if ({f_req_ready, f_resp_valid, f_resp_rdata, v_req_ready, v_resp_valid, v_resp_rdata,
             m_req_valid, m_req_write, m_req_addr, m_req_wdata} !== '0) begin
            n_err++;
            $display("FAIL midwait_reset got %b%b%b%b%b exp 0", f_req_ready, v_req_ready, f_resp_valid, v_resp_valid, m_req_valid);
        end
        m_resp_valid = 1; m_resp_rdata = {$urandom, $urandom};
        @(negedge clk);
        rst_n = 1; f_req_valid = 0; v_req_valid = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            m_resp_valid = 0;
            #1;
            n_vec++;
            if ({f_resp_valid, v_resp_valid, m_req_valid, f_resp_rdata, v_resp_rdata} !== '0) begin
                n_err++;
                $display("FAIL late_resp got %b%b%b exp 000", f_resp_valid, v_resp_valid, m_req_valid);
            end
        end
        last_v = 0; exp_rd_f = '0; exp_rd_v = '0;
    endtask

    task automatic test_random();
        bit            pend[2];
        logic          pw[2];
        logic [AW-1:0] pa[2];
        logic [DW-1:0] pd[2];
        bit            has_win, win;
        do_reset();
        pend[0] = 0; pend[1] = 0;
        for (int t = 0; t < 150; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = AW'($urandom);
                    pd[p] = {$urandom, $urandom};
                end else if (pend[p] && $urandom_range(0, 7) == 0) begin
                    pend[p] = 0;
                end
            end
            f_req_valid = pend[0]; f_req_write = pw[0]; f_req_addr = pa[0]; f_req_wdata = pd[0];
            v_req_valid = pend[1]; v_req_write = pw[1]; v_req_addr = pa[1]; v_req_wdata = pd[1];
            m_resp_valid = 1'($urandom_range(0, 1));
            m_req_ready  = 1'($urandom_range(0, 1));
            #1;
            has_win = pend[0] || pend[1];
            win = (pend[0] && pend[1]) ? !last_v : pend[1];
            n_vec++;
            if ({f_req_ready, v_req_ready} !== {has_win && !win, has_win && win}) begin
                n_err++;
                $display("FAIL rand_grant got %b exp %b", {f_req_ready, v_req_ready}, {has_win && !win, has_win && win});
            end
            if (!has_win) begin
                @(negedge clk);
            end else begin
                last_v = win;
                pend[win] = 0;
                m_req_ready = 0;
                serve(win, pw[win], pa[win], pd[win], $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
        f_req_valid = 0; v_req_valid = 0; m_resp_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single_f_read();
        test_conflict();
        test_v_write();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Per-core arbiter that shares one downstream memory bus (toward DRAM) between two upstream requesters: instruction fetch (port F) and vector load/store access (port V).
- Accepts at most one transaction at a time, forwards it downstream, and routes the single response back to the requester that owns it.
- Sits between the fetch stage / vector memory controller and the global memory bus.

Parameters:
- ADDR_W, 21, physical address width (matches phys_memory_address_t).
- DATA_W, 64, data word width.
- V_PRIORITY, 1, tie-break for the first arbitration after reset: 1 = V wins, 0 = F wins.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_req_valid  in  1  fetch request present.
- f_req_ready  out  1  fetch request accepted this cycle.
- f_req_write  in  1  1 = write, 0 = read.
- f_req_addr  in  ADDR_W  fetch address.
- f_req_wdata  in  DATA_W  fetch write data.
- f_resp_valid  out  1  one-cycle response pulse to fetch.
- f_resp_rdata  out  DATA_W  read data to fetch.
- v_req_valid, v_req_ready, v_req_write, v_req_addr, v_req_wdata, v_resp_valid, v_resp_rdata: same as the f_ set, for the vector port.
- m_req_valid  out  1  downstream request.
- m_req_ready  in  1  downstream accepts.
- m_req_write  out  1  downstream write flag.
- m_req_addr  out  ADDR_W  downstream address.
- m_req_wdata  out  DATA_W  downstream write data.
- m_resp_valid  in  1  downstream response (read data or write ack).
- m_resp_rdata  in  DATA_W  downstream read data.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (async, rst_n=0):
  - State = IDLE; owner = none.
  - All *_ready, *_valid and resp_valid outputs = 0; data and address outputs = 0.
  - Round-robin pointer set from V_PRIORITY.
- IDLE:
  - x_req_ready is combinational: asserted only for the grant winner, and only in IDLE.
  - Only one valid requester: it is granted.
  - Both valid: round-robin. The port not granted last wins; after reset, the V_PRIORITY port wins.
  - On grant, latch write, addr and wdata, record owner, update the pointer, go to ISSUE.
- ISSUE:
  - m_req_valid = 1 with the latched fields, held stable until m_req_ready.
  - First m_req_valid appears one cycle after the upstream handshake.
  - On m_req_valid & m_req_ready, drop m_req_valid next cycle and go to WAIT.
- WAIT:
  - On m_resp_valid, pulse the owner's resp_valid for exactly one cycle, registered (one cycle after m_resp_valid).
  - Owner's resp_rdata = m_resp_rdata, also registered.
  - Return to IDLE in the same edge. A new grant is possible in the cycle the response pulse is visible.
- Writes also complete through m_resp_valid; the response data is don't-care but is still forwarded.
- The non-owner's resp_valid is never asserted; its resp_rdata holds its last value.
- m_resp_valid outside WAIT is ignored.
- No response backpressure: requesters must accept the pulse.
- Throughput: at most one transaction in flight; minimum 3 cycles from grant to the next grant with a zero-wait memory.
- A requester that drops valid before its ready is not granted. No request is lost once ready=1.
- Async reset mid-transaction aborts it. A late m_resp_valid after reset is ignored, since the state is IDLE.

Optional Feature:
- Macro: CORE_MEM_ARB_STATS_EN.
- When defined, adds outputs:
  - f_grant_cnt  out 32: count of F grants.
  - v_grant_cnt  out 32: count of V grants.
  - conflict_cnt  out 32: count of IDLE cycles where both requesters were valid.
- All three reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Single F read:
  - Stimulus: f_req_valid with addr 0x00100; memory ready immediately; m_resp_rdata = 0x1122334455667788 two cycles later.
  - Required: m_req_addr = 0x00100, m_req_write = 0; f_resp_valid pulses once with that data; v_resp_valid stays 0.
- Simultaneous requests after reset (V_PRIORITY=1):
  - Stimulus: F reads 0x10 and V reads 0x20, both valid.
  - Required: V granted first (m_req_addr 0x20), then F (0x10). Next conflict grants V again only after F has been served.
- V write:
  - Stimulus: addr 0x1FFFF0, wdata 0xDEADBEEF, write = 1.
  - Required: m_req_write = 1 with both fields held while m_req_ready = 0 for 3 cycles; v_resp_valid pulses on the ack.
- Backpressure and stability:
  - Stimulus: F requests during WAIT.
  - Required: f_req_ready = 0 until IDLE; the request is then granted with unchanged fields.
- Reset mid-WAIT:
  - Stimulus: assert rst_n = 0 asynchronously, then m_resp_valid arrives.
  - Required: all outputs are 0 immediately; no resp_valid is produced.
- With CORE_MEM_ARB_STATS_EN:
  - Stimulus: the scenario-2 conflict, followed by the F grant.
  - Required: v_grant_cnt = 1, f_grant_cnt = 1, conflict_cnt ≥ 1.
